// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB write-back pipe: default widths, the
// hard-wired zero register index and the default-width stage payload layout.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mem_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Register index that is never written back.
  localparam int ZERO_REG   = 0;

  // Default-width view of one pipe stage; field order is the bit order
  // used by every stage register (valid is the MSB).
  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [REG_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_payload_t;

endpackage

// File: rtl/mem_wb_pipe_ctl_pipe_stage.sv
// One write-back payload register with rst > flush > hold > load priority.
// Latency: 1 cycle from d_i to q_o when not held or flushed.
// Backpressure: hold_i freezes the register; flush_i zeroes it (bubble).
// Ports: clk/rst (sync, active-high), flush_i, hold_i, d_i[W], q_o[W].
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         hold_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else if (!hold_i) begin
      stage_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/mem_wb_pipe_ctl.sv
// MEM/WB pipe: muxes load/ALU result, carries it DEPTH stages to the regfile,
// generates write enable, WB forwarding hits and a retired-instruction count.
// Latency: DEPTH cycles input->outputs; stall holds all stages, flush bubbles all.
// Ports: clk, rst (sync, active-high), stall, flush, valid_in, reg_write_in,
//   mem_to_reg_in, alu_in/mem_in[DATA_W], rd_in/rs_a/rs_b[REG_W]; outputs
//   valid_out, reg_write_out, data_out, rd_out, wb_en, fwd_hit_a/b, retire_cnt.
module mem_wb_pipe_ctl
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [REG_W-1:0]  rs_a,
  input  logic [REG_W-1:0]  rs_b,
  output logic              valid_out,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] data_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              wb_en,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [CNT_W-1:0]  retire_cnt
);

  // Same layout as wb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t         in_pl;
  payload_t         out_pl;
  logic [PW-1:0]    stage_q [DEPTH];
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] retire_cnt_d;

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
      $error("mem_wb_pipe_ctl: DEPTH must be within 1..4");
    end
  endgenerate

  always_comb begin
    in_pl           = '0;
    in_pl.valid     = valid_in;
    in_pl.reg_write = reg_write_in;
    in_pl.rd        = rd_in;
    in_pl.data      = mem_to_reg_in ? mem_in : alu_in;
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [PW-1:0] stage_in;
      if (k == 0) begin : g_head
        assign stage_in = in_pl;
      end else begin : g_tail
        assign stage_in = stage_q[k-1];
      end

      pipe_stage #(
        .W (PW)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .hold_i  (stall),
        .d_i     (stage_in),
        .q_o     (stage_q[k])
      );
    end
  endgenerate

  assign out_pl        = payload_t'(stage_q[DEPTH-1]);
  assign valid_out     = out_pl.valid;
  assign reg_write_out = out_pl.reg_write;
  assign data_out      = out_pl.data;
  assign rd_out        = out_pl.rd;

  // Bubbles and writes to the zero register never reach the regfile.
  assign wb_en     = valid_out & reg_write_out & (rd_out != REG_W'(ZERO_REG));
  assign fwd_hit_a = wb_en & (rd_out == rs_a);
  assign fwd_hit_b = wb_en & (rd_out == rs_b);

  // A held instruction may rewrite the regfile every cycle, but it is only
  // counted on the edge where it actually leaves the last stage.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (valid_out && !flush && !stall) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_ctl.sv
// Directed bench: three instances share one stimulus stream --
// d1 (DEPTH=1), d3 (DEPTH=3) and dc (DEPTH=1, 4-bit retire counter).
module tb_mem_wb_pipe_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [31:0] alu_in;
  logic [31:0] mem_in;
  logic [4:0]  rd_in;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;

  logic        d1_valid, d1_rw, d1_wb, d1_fa, d1_fb;
  logic [31:0] d1_data, d1_cnt;
  logic [4:0]  d1_rd;
  logic        d3_valid, d3_rw, d3_wb, d3_fa, d3_fb;
  logic [31:0] d3_data, d3_cnt;
  logic [4:0]  d3_rd;
  logic        dc_valid, dc_rw, dc_wb, dc_fa, dc_fb;
  logic [31:0] dc_data;
  logic [3:0]  dc_cnt;
  logic [4:0]  dc_rd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_ctl #(.DEPTH(1)) d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_in(alu_in), .mem_in(mem_in), .rd_in(rd_in), .rs_a(rs_a), .rs_b(rs_b),
    .valid_out(d1_valid), .reg_write_out(d1_rw), .data_out(d1_data),
    .rd_out(d1_rd), .wb_en(d1_wb), .fwd_hit_a(d1_fa), .fwd_hit_b(d1_fb),
    .retire_cnt(d1_cnt)
  );

  mem_wb_pipe_ctl #(.DEPTH(3)) d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_in(alu_in), .mem_in(mem_in), .rd_in(rd_in), .rs_a(rs_a), .rs_b(rs_b),
    .valid_out(d3_valid), .reg_write_out(d3_rw), .data_out(d3_data),
    .rd_out(d3_rd), .wb_en(d3_wb), .fwd_hit_a(d3_fa), .fwd_hit_b(d3_fb),
    .retire_cnt(d3_cnt)
  );

  mem_wb_pipe_ctl #(.DEPTH(1), .CNT_W(4)) dc (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .alu_in(alu_in), .mem_in(mem_in), .rd_in(rd_in), .rs_a(rs_a), .rs_b(rs_b),
    .valid_out(dc_valid), .reg_write_out(dc_rw), .data_out(dc_data),
    .rd_out(dc_rd), .wb_en(dc_wb), .fwd_hit_a(dc_fa), .fwd_hit_b(dc_fb),
    .retire_cnt(dc_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; new inputs are
  // applied at the same point and are captured on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd);
    valid_in      = v;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    alu_in        = alu;
    mem_in        = mem;
    rd_in         = rd;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs_a = 5'd0; rs_b = 5'd0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    // Reset for two cycles: everything reads zero.
    tick(); tick();
    chk("rst_valid",  {63'd0, d1_valid}, 64'd0);
    chk("rst_data",   {32'd0, d1_data},  64'd0);
    chk("rst_rd",     {59'd0, d1_rd},    64'd0);
    chk("rst_wb_en",  {63'd0, d1_wb},    64'd0);
    chk("rst_cnt",    {32'd0, d1_cnt},   64'd0);
    chk("rst_d3_valid", {63'd0, d3_valid}, 64'd0);

    // E1: ALU result 0xAA -> r5.
    rst = 1'b0;
    rs_a = 5'd5; rs_b = 5'd6;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_00AA, 32'h5555_5555, 5'd5);
    tick();
    chk("e1_data",  {32'd0, d1_data}, 64'hAA);
    chk("e1_rd",    {59'd0, d1_rd},   64'd5);
    chk("e1_wb_en", {63'd0, d1_wb},   64'd1);
    chk("e1_cnt",   {32'd0, d1_cnt},  64'd0);
    chk("e1_fwd_a", {63'd0, d1_fa},   64'd1);
    chk("e1_fwd_b", {63'd0, d1_fb},   64'd0);
    chk("e1_d3_valid", {63'd0, d3_valid}, 64'd0);

    // E2: load result selected over ALU result.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7);
    tick();
    chk("e2_data",    {32'd0, d1_data}, 64'hDEAD_BEEF);
    chk("e2_rd",      {59'd0, d1_rd},   64'd7);
    chk("e2_cnt",     {32'd0, d1_cnt},  64'd1);
    chk("e2_d3_data", {32'd0, d3_data}, 64'd0);

    // E3: write to r0 is valid but never enables the regfile.
    rs_a = 5'd0;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd0);
    tick();
    chk("r0_valid", {63'd0, d1_valid}, 64'd1);
    chk("r0_wb_en", {63'd0, d1_wb},    64'd0);
    chk("r0_fwd_a", {63'd0, d1_fa},    64'd0);
    chk("r0_cnt",   {32'd0, d1_cnt},   64'd2);
    chk("e3_d3_data",  {32'd0, d3_data}, 64'hAA);
    chk("e3_d3_rd",    {59'd0, d3_rd},   64'd5);

    // E4: bubble carrying rd=9; wb_en and forwarding are gated by valid.
    rs_a = 5'd9; rs_b = 5'd10;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd9);
    tick();
    chk("bub_valid", {63'd0, d1_valid}, 64'd0);
    chk("bub_rw",    {63'd0, d1_rw},    64'd1);
    chk("bub_rd",    {59'd0, d1_rd},    64'd9);
    chk("bub_wb_en", {63'd0, d1_wb},    64'd0);
    chk("bub_fwd_a", {63'd0, d1_fa},    64'd0);
    chk("bub_fwd_b", {63'd0, d1_fb},    64'd0);
    chk("r0_cnt_inc", {32'd0, d1_cnt},  64'd3);
    chk("e4_d3_data", {32'd0, d3_data}, 64'hDEAD_BEEF);
    chk("e4_d3_cnt",  {32'd0, d3_cnt},  64'd1);

    // E5: valid r9 write: only source A matches.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd9);
    tick();
    chk("fwd_a_hit",  {63'd0, d1_fa}, 64'd1);
    chk("fwd_b_miss", {63'd0, d1_fb}, 64'd0);
    chk("bub_no_cnt", {32'd0, d1_cnt}, 64'd3);
    chk("e5_d3_wb_en", {63'd0, d3_wb}, 64'd0);

    // E6..E8: fill d3 with rd 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i), 32'h0, 5'(i));
      tick();
    end
    chk("fill_d3_rd",   {59'd0, d3_rd},   64'd1);
    chk("fill_d3_data", {32'd0, d3_data}, 64'h11);
    chk("fill_d3_cnt",  {32'd0, d3_cnt},  64'd4);
    chk("fill_d1_cnt",  {32'd0, d1_cnt},  64'd6);

    // Stall 4 cycles with new inputs present: nothing moves.
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hFF, 32'h0, 5'd31);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_d3_rd", {59'd0, d3_rd}, 64'd1);
    end
    chk("stall_d3_data",  {32'd0, d3_data}, 64'h11);
    chk("stall_d3_valid", {63'd0, d3_valid}, 64'd1);
    chk("stall_d3_wb_en", {63'd0, d3_wb},   64'd1);
    chk("stall_d3_cnt",   {32'd0, d3_cnt},  64'd4);
    chk("stall_d1_rd",    {59'd0, d1_rd},   64'd3);
    chk("stall_d1_cnt",   {32'd0, d1_cnt},  64'd6);

    // Flush together with stall: flush wins, and nothing is retired.
    flush = 1'b1;
    tick();
    chk("flush_d3_valid", {63'd0, d3_valid}, 64'd0);
    chk("flush_d3_rd",    {59'd0, d3_rd},    64'd0);
    chk("flush_d3_data",  {32'd0, d3_data},  64'd0);
    chk("flush_d3_wb_en", {63'd0, d3_wb},    64'd0);
    chk("flush_d3_cnt",   {32'd0, d3_cnt},   64'd4);
    chk("flush_d1_cnt",   {32'd0, d1_cnt},   64'd6);
    flush = 1'b0; stall = 1'b0;

    // Flush must also have cleared the middle of d3: one edge later the
    // last stage shows what was in stage 1 (zero), not rd 2.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("flush_mid_rd", {59'd0, d3_rd}, 64'd0);

    // Counter wrap on the 4-bit instance, starting from a fresh reset.
    rst = 1'b1;
    tick();
    chk("rst2_dc_cnt", {60'd0, dc_cnt}, 64'd0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd4);
    for (int i = 0; i < 16; i++) tick();
    chk("wrap_cnt_f", {60'd0, dc_cnt}, 64'hF);
    tick();
    chk("wrap_cnt_0", {60'd0, dc_cnt}, 64'h0);
    tick();
    chk("wrap_cnt_1", {60'd0, dc_cnt}, 64'h1);
    chk("nowrap_d1_cnt", {32'd0, d1_cnt}, 64'd17);

    // Reset mid-stream clears counters and pipeline on the same edge.
    rst = 1'b1;
    tick();
    chk("mrst_dc_cnt",   {60'd0, dc_cnt},   64'd0);
    chk("mrst_dc_valid", {63'd0, dc_valid}, 64'd0);
    chk("mrst_d1_cnt",   {32'd0, d1_cnt},   64'd0);
    chk("mrst_d3_valid", {63'd0, d3_valid}, 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {63'd0, dc_valid}, 64'd1);
    chk("post_rst_cnt",   {60'd0, dc_cnt},   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_ctl.md
Name: mem_wb_pipe_ctl

Overview:
- Parametrised successor to the fixed MEM/WB pipe register.
- Carries the write-back payload from the MEM stage to the register file across DEPTH register stages.
- Adds a valid bit, stall (hold), flush (bubble), a mem-to-reg result select, regfile write-enable generation, WB-stage forwarding hit detection, and a retired-instruction counter.
- Sits between the data-memory stage and the register file write port.

Parameters:
- DATA_W, 32, width of the result datapath
- REG_W, 5, register-index width
- DEPTH, 1, number of register stages, legal range 1..4
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold every stage
- flush  in  1  invalidate every stage
- valid_in  in  1  incoming instruction valid
- reg_write_in  in  1  instruction writes the register file
- mem_to_reg_in  in  1  1 selects mem_in, 0 selects alu_in
- alu_in  in  DATA_W  ALU result
- mem_in  in  DATA_W  load data
- rd_in  in  REG_W  destination register
- rs_a  in  REG_W  consumer source A, for forwarding compare
- rs_b  in  REG_W  consumer source B
- valid_out  out  1  last-stage valid
- reg_write_out  out  1  last-stage reg_write
- data_out  out  DATA_W  last-stage write-back data
- rd_out  out  REG_W  last-stage destination
- wb_en  out  1  regfile write enable
- fwd_hit_a  out  1  WB result matches rs_a
- fwd_hit_b  out  1  WB result matches rs_b
- retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Input mux is combinational before stage 0: payload = mem_to_reg_in ? mem_in : alu_in.
- Each stage holds {valid, reg_write, data, rd}. Stage 0 loads the inputs; stage k loads stage k-1. Outputs come from stage DEPTH-1.
- Total latency is DEPTH cycles from the input sample to the outputs when there is no stall.
- Per-edge priority is rst > flush > stall > advance:
  - rst: every stage field = 0 and retire_cnt = 0. All outputs therefore read 0 on the cycle after the rst edge.
  - flush: every stage's valid, reg_write, rd and data = 0. The input is not captured, because a flush discards the in-flight instruction as well.
  - stall: every stage holds, the input is not captured, and outputs are unchanged.
  - advance: the pipeline shifts by one stage.
- wb_en = valid_out & reg_write_out & (rd_out != 0). This is combinational from stage registers only. Register 0 is never written.
- fwd_hit_a = wb_en & (rd_out == rs_a); fwd_hit_b is the same with rs_b. Both are combinational.
- retire_cnt increments by 1 on an edge where valid_out=1, rst=0, flush=0 and stall=0. It wraps modulo 2^CNT_W with no saturation.
- A held (stalled) valid_out re-asserts wb_en every cycle. Repeated writes of the same value are permitted and retire_cnt is not bumped.
- Simultaneous flush and stall: flush wins.
- rst asserted mid-operation: all state, including the counter, is cleared on that edge. No partial pipeline contents survive.
- valid_in=0 propagates as a bubble. A bubble's reg_write and rd are captured as given, but wb_en is gated by valid.
- DEPTH outside 1..4 is a compile-time error, raised by a generate-time check.

Decomposition:
- Shared package mem_wb_pkg holds:
  - default DATA_W and REG_W constants
  - the ZERO_REG constant (0)
  - a packed struct typedef wb_payload_t {valid, reg_write, rd, data}
- One sub-module, pipe_stage, is natural. It is a single payload register with rst/flush/stall/enable priority and is instantiated DEPTH times via generate. The mux, wb_en, forwarding and counter logic stay in the top level.

Test Plan:
1. DEPTH=1; rst high 2 cycles, then drive valid_in=1, reg_write_in=1, mem_to_reg_in=0, alu_in=0x0000_00AA, rd_in=5 -> the following cycle data_out=0xAA, rd_out=5, wb_en=1, retire_cnt=0. retire_cnt becomes 1 after the next un-stalled edge.
2. mem_to_reg_in=1, mem_in=0xDEAD_BEEF, alu_in=0x1234, rd_in=7 -> data_out=0xDEADBEEF after DEPTH cycles. With DEPTH=3, outputs stay at the prior value for cycles 1-2 and update on cycle 3.
3. rd_in=0, reg_write_in=1, valid_in=1 -> valid_out=1, wb_en=0, fwd_hit_a=0 even with rs_a=0. retire_cnt still increments.
4. DEPTH=3 with a full pipeline (rd 1,2,3); stall high 4 cycles -> outputs frozen and retire_cnt constant. Then flush and stall high together for 1 cycle -> next cycle valid_out=0, rd_out=0, data_out=0, wb_en=0.
5. Forwarding: valid WB instruction with rd_out=9, rs_a=9, rs_b=10 -> fwd_hit_a=1, fwd_hit_b=0. Same with valid_out=0 (bubble) -> both 0.
6. CNT_W=4; retire 17 consecutive valid instructions -> retire_cnt reads 0xF then wraps to 0x0, then 0x1. Assert rst mid-stream -> retire_cnt=0 and valid_out=0 on the next cycle.
